ahblite_slave_mux: RTL and testbench
====================================

Name: ahblite_slave_mux

Overview:
- Response-side companion of the AHB-Lite address decoder. Consumes the decoder's P0..P4_HSEL outputs and the slaves' responses, and returns a single HRDATA/HREADY/HRESP to the Cortex-M0 master.
- Holds the registered data-phase slave select.
- Contains the default slave, which returns an ERROR response for unmapped transfers.
- Contains a hung-slave watchdog that aborts a stalled data phase with ERROR.

Parameters:
- Port0_en..Port4_en, default 1 each: slave port N is muxed when 1. When 0, the port's HSEL is ignored and the transfer goes to the default slave.
- TIMEOUT_CYCLES, default 1024: number of consecutive wait cycles before a forced abort. 0 disables the watchdog. Legal range 0..65535; the counter is 16 bits.

Ports:
- HCLK  in  1  system clock
- HRESET  in  1  synchronous, active-high reset
- HTRANS  in  2  master transfer type; bit 1 = NONSEQ/SEQ (active transfer)
- Pn_HSEL (n=0..4)  in  1 each  address-phase select from the decoder
- Pn_HREADYOUT (n=0..4)  in  1 each  slave ready
- Pn_HRESP (n=0..4)  in  1 each  slave response; 0 = OKAY, 1 = ERROR
- Pn_HRDATA (n=0..4)  in  32 each  slave read data
- HREADY  out  1  muxed ready, to the master and to all slaves
- HRESP  out  1  muxed response
- HRDATA  out  32  muxed read data
- HTIMEOUT  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (HRESET=1 at a HCLK edge) clears:
  - sel_q = 0, dflt_q = 0, state = IDLE, wait counter = 0, HTIMEOUT = 0.
  - Outputs become HREADY=1, HRESP=0, HRDATA=0.
  - Reset mid-transfer abandons the transfer; no ERROR is generated.
- Address-phase capture, at each HCLK edge where HREADY=1:
  - sel_q <= one-hot of the enabled HSEL set. If several bits are set, the lowest index wins.
  - dflt_q <= HTRANS[1] & no enabled HSEL.
  - If HREADY=0, sel_q and dflt_q hold.
  - IDLE/BUSY (HTRANS[1]=0) with no HSEL clears both.
- Data-phase output (combinational from the registers):
  - sel_q bit n set and state=IDLE: HRDATA=Pn_HRDATA, HREADY=Pn_HREADYOUT, HRESP=Pn_HRESP.
  - Nothing selected and state=IDLE: HREADY=1, HRESP=0, HRDATA=0 (zero-wait OKAY).
  - In ERR1/ERR2: HRDATA=0 and the slave signals are ignored.
- State machine, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 on the edge capturing dflt_q=1, or on watchdog expiry.
  - ERR1 drives HREADY=0, HRESP=1, then -> ERR2 unconditionally.
  - ERR2 drives HREADY=1, HRESP=1, then -> IDLE. The ERR2 edge is also an address-phase capture.
  - This is the AHB two-cycle ERROR response; the master sees exactly 1 wait cycle.
- Watchdog:
  - Counter increments each cycle in IDLE where sel_q≠0 and the selected Pn_HREADYOUT=0.
  - Counter clears when HREADY=1 or state≠IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 while still waiting, the next edge enters ERR1 and HTIMEOUT pulses high for that ERR1 cycle.
  - Effect: the master sees TIMEOUT_CYCLES wait cycles, then ERR1 and ERR2. TIMEOUT_CYCLES=1 gives 1 wait cycle, then ERR1.
  - After an abort, sel_q clears at ERR2 unless a new transfer is captured. Late HREADYOUT/HRESP from the aborted slave are ignored.
- Slave HRESP=1 is passed through unmodified, including the slave's own two-cycle sequence.
- Selected slave wait states extend the data phase and block capture of the next address phase.
- A disabled port (Portn_en=0) with its HSEL=1 and an active HTRANS is treated as unmapped and gets ERROR.

Test Plan:
- Reset: assert HRESET for 2 cycles mid-ERR1 -> next cycle HREADY=1, HRESP=0, HRDATA=0, HTIMEOUT=0, state IDLE.
- Read P1: P1_HSEL=1, HTRANS=2'b10, P1_HRDATA=32'hDEADBEEF, P1_HREADYOUT=0 for 2 cycles then 1 -> HREADY low for 2 cycles, then high with HRDATA=32'hDEADBEEF, HRESP=0.
- Unmapped NONSEQ to 0x30000000 (all HSEL=0, HTRANS=2'b10) -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then IDLE. The same stimulus with HTRANS=2'b00 -> HREADY=1, HRESP=0, no error.
- Back-to-back: P0 read then P4 read on consecutive cycles, both slaves zero-wait with distinct data 32'h11111111 and 32'h44444444 -> HRDATA shows 32'h11111111 then 32'h44444444 on consecutive cycles.
- Watchdog with TIMEOUT_CYCLES=4: P4 selected, P4_HREADYOUT stuck at 0 -> exactly 4 HREADY=0 wait cycles, then ERR1 with a one-cycle HTIMEOUT pulse, then ERR2, then a new P0 transfer completes OKAY. With TIMEOUT_CYCLES=0, a stall of 5000 cycles -> no error.
- Multiple HSEL (P2_HSEL=P3_HSEL=1) -> P2 data returned. Port2_en=0 with P2_HSEL=1 and HTRANS=NONSEQ -> ERROR response.

Source files
------------

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response mux: registered data-phase select, default slave ERROR
// responder and hung-slave watchdog for the Cortex-M0 master.
module ahblite_slave_mux #(
  parameter bit          Port0_en       = 1'b1,
  parameter bit          Port1_en       = 1'b1,
  parameter bit          Port2_en       = 1'b1,
  parameter bit          Port3_en       = 1'b1,
  parameter bit          Port4_en       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P4_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P4_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic        P4_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic [31:0] P4_HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        HTIMEOUT
);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;

  localparam logic [4:0]  PORT_EN = {Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WD_LAST = 16'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [4:0]  sel_q;
  logic        dflt_q;
  logic [15:0] wait_cnt;

  logic [4:0]  hsel_en, sel_first, hro_vec, hresp_vec;
  logic [31:0] rdata_vec [5];
  logic        slave_ready, slave_resp;
  logic [31:0] slave_data;
  logic        waiting, wd_fire, capture_err;

  assign hsel_en   = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & PORT_EN;
  assign sel_first = hsel_en & (~hsel_en + 5'd1);
  assign hro_vec   = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
  assign hresp_vec = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
  assign rdata_vec[0] = P0_HRDATA;
  assign rdata_vec[1] = P1_HRDATA;
  assign rdata_vec[2] = P2_HRDATA;
  assign rdata_vec[3] = P3_HRDATA;
  assign rdata_vec[4] = P4_HRDATA;

  always_comb begin
    slave_ready = 1'b1;
    slave_resp  = 1'b0;
    slave_data  = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (sel_q[i]) begin
        slave_ready = hro_vec[i];
        slave_resp  = hresp_vec[i];
        slave_data  = rdata_vec[i];
      end
    end
  end

  always_comb begin
    HREADY = slave_ready;
    HRESP  = slave_resp;
    HRDATA = slave_data;
    case (state)
      ERR1: begin HREADY = 1'b0; HRESP = 1'b1; HRDATA = '0; end
      ERR2: begin HREADY = 1'b1; HRESP = 1'b1; HRDATA = '0; end
      default: ;
    endcase
  end

  assign waiting     = (state == IDLE) && (|sel_q) && !dflt_q && !slave_ready;
  assign wd_fire     = WD_EN && waiting && (wait_cnt == WD_LAST);
  assign capture_err = HREADY && HTRANS[1] && (hsel_en == '0);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= IDLE;
      sel_q    <= '0;
      dflt_q   <= 1'b0;
      wait_cnt <= '0;
      HTIMEOUT <= 1'b0;
    end else begin
      HTIMEOUT <= wd_fire;
      if (HREADY) begin
        sel_q  <= sel_first;
        dflt_q <= HTRANS[1] && (hsel_en == '0);
      end
      if (WD_EN && waiting && !wd_fire)
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= '0;
      case (state)
        IDLE:    if (capture_err || wd_fire) state <= ERR1;
        ERR1:    state <= ERR2;
        // ERR2 completes the previous transfer, so an unmapped address captured here needs its own ERROR
        ERR2:    state <= capture_err ? ERR1 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Bench for ahblite_slave_mux: directed scenarios plus randomized traffic
// checked against a transaction-level response model.
module tb_ahblite_slave_mux;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  HTRANS;
  logic [4:0]  hsel, hro, hresp;
  logic [31:0] hrdata [5];

  logic        a_ready, a_resp, a_tmo;
  logic [31:0] a_data;
  logic        n_ready, n_resp, n_tmo;
  logic [31:0] n_data;
  logic        d_ready, d_resp, d_tmo;
  logic [31:0] d_data;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ahblite_slave_mux #(.TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
    .P0_HREADYOUT(hro[0]), .P1_HREADYOUT(hro[1]), .P2_HREADYOUT(hro[2]),
    .P3_HREADYOUT(hro[3]), .P4_HREADYOUT(hro[4]),
    .P0_HRESP(hresp[0]), .P1_HRESP(hresp[1]), .P2_HRESP(hresp[2]), .P3_HRESP(hresp[3]), .P4_HRESP(hresp[4]),
    .P0_HRDATA(hrdata[0]), .P1_HRDATA(hrdata[1]), .P2_HRDATA(hrdata[2]),
    .P3_HRDATA(hrdata[3]), .P4_HRDATA(hrdata[4]),
    .HREADY(a_ready), .HRESP(a_resp), .HRDATA(a_data), .HTIMEOUT(a_tmo)
  );

  ahblite_slave_mux #(.TIMEOUT_CYCLES(0)) dut_nwd (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
    .P0_HREADYOUT(hro[0]), .P1_HREADYOUT(hro[1]), .P2_HREADYOUT(hro[2]),
    .P3_HREADYOUT(hro[3]), .P4_HREADYOUT(hro[4]),
    .P0_HRESP(hresp[0]), .P1_HRESP(hresp[1]), .P2_HRESP(hresp[2]), .P3_HRESP(hresp[3]), .P4_HRESP(hresp[4]),
    .P0_HRDATA(hrdata[0]), .P1_HRDATA(hrdata[1]), .P2_HRDATA(hrdata[2]),
    .P3_HRDATA(hrdata[3]), .P4_HRDATA(hrdata[4]),
    .HREADY(n_ready), .HRESP(n_resp), .HRDATA(n_data), .HTIMEOUT(n_tmo)
  );

  ahblite_slave_mux #(.Port2_en(1'b0), .TIMEOUT_CYCLES(4)) dut_p2off (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
    .P0_HREADYOUT(hro[0]), .P1_HREADYOUT(hro[1]), .P2_HREADYOUT(hro[2]),
    .P3_HREADYOUT(hro[3]), .P4_HREADYOUT(hro[4]),
    .P0_HRESP(hresp[0]), .P1_HRESP(hresp[1]), .P2_HRESP(hresp[2]), .P3_HRESP(hresp[3]), .P4_HRESP(hresp[4]),
    .P0_HRDATA(hrdata[0]), .P1_HRDATA(hrdata[1]), .P2_HRDATA(hrdata[2]),
    .P3_HRDATA(hrdata[3]), .P4_HRDATA(hrdata[4]),
    .HREADY(d_ready), .HRESP(d_resp), .HRDATA(d_data), .HTIMEOUT(d_tmo)
  );

  task automatic cyc();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic idle_inputs();
    HTRANS = 2'b00;
    hsel   = '0;
    hro    = '1;
    hresp  = '0;
    for (int i = 0; i < 5; i++) hrdata[i] = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    HRESET = 1'b1;
    cyc();
    cyc();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    HTRANS = 2'b10;
    cyc();
    HTRANS = 2'b00;
    #1;
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_pre_err1 HREADY got=%b want=0", a_ready); end
    HRESET = 1'b1;
    cyc();
    cyc();
    HRESET = 1'b0;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_hready got=%b want=1", a_ready); end
    total++; if (a_resp !== 1'b0) begin bad++; $display("FAIL reset_hresp got=%b want=0", a_resp); end
    total++; if (a_data !== 32'h0) begin bad++; $display("FAIL reset_hrdata got=%h want=0", a_data); end
    total++; if (a_tmo !== 1'b0) begin bad++; $display("FAIL reset_htimeout got=%b want=0", a_tmo); end
    cyc();
    total++; if (a_ready !== 1'b1 || a_resp !== 1'b0) begin bad++; $display("FAIL reset_idle_after ready/resp got=%b/%b want=1/0", a_ready, a_resp); end
  endtask

  task automatic test_read_p1();
    apply_reset();
    hsel[1] = 1'b1; HTRANS = 2'b10; hrdata[1] = 32'hDEADBEEF; hro[1] = 1'b0;
    cyc();
    hsel = '0; HTRANS = 2'b00;
    for (int w = 0; w < 2; w++) begin
      #1;
      total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL p1_wait%0d HREADY got=%b want=0", w, a_ready); end
      cyc();
    end
    hro[1] = 1'b1;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL p1_done HREADY got=%b want=1", a_ready); end
    total++; if (a_data !== 32'hDEADBEEF) begin bad++; $display("FAIL p1_data got=%h want=deadbeef", a_data); end
    total++; if (a_resp !== 1'b0) begin bad++; $display("FAIL p1_resp got=%b want=0", a_resp); end
    cyc();
  endtask

  task automatic test_unmapped();
    apply_reset();
    HTRANS = 2'b10;
    cyc();
    HTRANS = 2'b00;
    #1;
    total++; if (a_ready !== 1'b0 || a_resp !== 1'b1) begin bad++; $display("FAIL unmapped_err1 ready/resp got=%b/%b want=0/1", a_ready, a_resp); end
    cyc();
    total++; if (a_ready !== 1'b1 || a_resp !== 1'b1) begin bad++; $display("FAIL unmapped_err2 ready/resp got=%b/%b want=1/1", a_ready, a_resp); end
    cyc();
    total++; if (a_ready !== 1'b1 || a_resp !== 1'b0) begin bad++; $display("FAIL unmapped_idle ready/resp got=%b/%b want=1/0", a_ready, a_resp); end
    cyc();
    total++; if (a_ready !== 1'b1 || a_resp !== 1'b0) begin bad++; $display("FAIL unmapped_htrans_idle ready/resp got=%b/%b want=1/0", a_ready, a_resp); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    hrdata[0] = 32'h11111111; hrdata[4] = 32'h44444444;
    hsel[0] = 1'b1; HTRANS = 2'b10;
    cyc();
    hsel[0] = 1'b0; hsel[4] = 1'b1;
    #1;
    total++; if (a_ready !== 1'b1 || a_data !== 32'h11111111) begin bad++; $display("FAIL b2b_p0 ready/data got=%b/%h want=1/11111111", a_ready, a_data); end
    cyc();
    hsel = '0; HTRANS = 2'b00;
    #1;
    total++; if (a_ready !== 1'b1 || a_data !== 32'h44444444) begin bad++; $display("FAIL b2b_p4 ready/data got=%b/%h want=1/44444444", a_ready, a_data); end
    cyc();
  endtask

  task automatic test_watchdog();
    apply_reset();
    hsel[4] = 1'b1; HTRANS = 2'b10; hro[4] = 1'b0;
    hrdata[0] = 32'hA5A5_0000;
    cyc();
    hsel = '0; HTRANS = 2'b00;
    for (int w = 0; w < 4; w++) begin
      #1;
      total++; if (a_ready !== 1'b0 || a_tmo !== 1'b0 || a_resp !== 1'b0) begin bad++; $display("FAIL wd_wait%0d ready/tmo/resp got=%b/%b/%b want=0/0/0", w, a_ready, a_tmo, a_resp); end
      cyc();
    end
    #1;
    total++; if (a_ready !== 1'b0 || a_resp !== 1'b1 || a_tmo !== 1'b1) begin bad++; $display("FAIL wd_err1 ready/resp/tmo got=%b/%b/%b want=0/1/1", a_ready, a_resp, a_tmo); end
    cyc();
    hsel[0] = 1'b1; HTRANS = 2'b10;
    #1;
    total++; if (a_ready !== 1'b1 || a_resp !== 1'b1 || a_tmo !== 1'b0) begin bad++; $display("FAIL wd_err2 ready/resp/tmo got=%b/%b/%b want=1/1/0", a_ready, a_resp, a_tmo); end
    cyc();
    hsel = '0; HTRANS = 2'b00;
    #1;
    total++; if (a_ready !== 1'b1 || a_resp !== 1'b0 || a_data !== 32'hA5A5_0000) begin bad++; $display("FAIL wd_next_p0 ready/resp/data got=%b/%b/%h want=1/0/a5a50000", a_ready, a_resp, a_data); end
    cyc();
    hro[4] = 1'b1;
  endtask

  task automatic test_no_watchdog();
    int odd;
    odd = 0;
    apply_reset();
    hsel[4] = 1'b1; HTRANS = 2'b10; hro[4] = 1'b0;
    cyc();
    hsel = '0; HTRANS = 2'b00;
    for (int c = 0; c < 5000; c++) begin
      #1;
      if (n_ready !== 1'b0 || n_resp !== 1'b0 || n_tmo !== 1'b0) odd++;
      cyc();
    end
    total++; if (odd !== 0) begin bad++; $display("FAIL nowd_stall bad_cycles got=%0d want=0", odd); end
    hro[4] = 1'b1; hrdata[4] = 32'h0BAD_F00D;
    #1;
    total++; if (n_ready !== 1'b1 || n_resp !== 1'b0 || n_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL nowd_release ready/resp/data got=%b/%b/%h want=1/0/0badf00d", n_ready, n_resp, n_data); end
    cyc();
  endtask

  task automatic test_multi_hsel();
    apply_reset();
    hrdata[2] = 32'h2222_2222; hrdata[3] = 32'h3333_3333;
    hsel[2] = 1'b1; hsel[3] = 1'b1; HTRANS = 2'b10;
    cyc();
    hsel = '0; HTRANS = 2'b00;
    #1;
    total++; if (a_data !== 32'h2222_2222 || a_ready !== 1'b1) begin bad++; $display("FAIL multi_hsel data/ready got=%h/%b want=22222222/1", a_data, a_ready); end
    cyc();
  endtask

  task automatic test_port_disabled();
    apply_reset();
    hrdata[2] = 32'h2222_2222;
    hsel[2] = 1'b1; HTRANS = 2'b10;
    cyc();
    hsel = '0; HTRANS = 2'b00;
    #1;
    total++; if (d_ready !== 1'b0 || d_resp !== 1'b1 || d_data !== 32'h0) begin bad++; $display("FAIL p2off_err1 ready/resp/data got=%b/%b/%h want=0/1/0", d_ready, d_resp, d_data); end
    total++; if (a_ready !== 1'b1 || a_data !== 32'h2222_2222) begin bad++; $display("FAIL p2on_ok ready/data got=%b/%h want=1/22222222", a_ready, a_data); end
    cyc();
    total++; if (d_ready !== 1'b1 || d_resp !== 1'b1) begin bad++; $display("FAIL p2off_err2 ready/resp got=%b/%b want=1/1", d_ready, d_resp); end
    cyc();
  endtask

  // Model: m_tgt = slave owning the data phase (-1 none), m_err = position
  // within a two-cycle ERROR response (0 none), m_wait = wait cycles so far.
  task automatic test_random();
    int m_tgt, m_err, m_wait, pick;
    bit m_tmo, e_ready, e_resp;
    logic [31:0] e_data;
    apply_reset();
    m_tgt = -1; m_err = 0; m_wait = 0; m_tmo = 1'b0;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0: hsel = 5'($urandom);
        1: hsel = 5'(1 << $urandom_range(0, 4));
        default: hsel = '0;
      endcase
      HTRANS = 2'($urandom);
      for (int i = 0; i < 5; i++) begin
        hro[i]    = ((c / 40) % 2 == 1) ? ($urandom_range(0, 9) >= 7) : ($urandom_range(0, 9) >= 2);
        hresp[i]  = ($urandom_range(0, 9) == 0);
        hrdata[i] = $urandom;
      end
      #1;
      if (m_err == 1) begin e_ready = 0; e_resp = 1; e_data = 0; end
      else if (m_err == 2) begin e_ready = 1; e_resp = 1; e_data = 0; end
      else if (m_tgt >= 0) begin e_ready = hro[m_tgt]; e_resp = hresp[m_tgt]; e_data = hrdata[m_tgt]; end
      else begin e_ready = 1; e_resp = 0; e_data = 0; end
      total++;
      if (a_ready !== e_ready || a_resp !== e_resp || a_data !== e_data || a_tmo !== m_tmo) begin
        bad++;
        $display("FAIL rand_cycle%0d ready/resp/data/tmo got=%b/%b/%h/%b want=%b/%b/%h/%b",
                 c, a_ready, a_resp, a_data, a_tmo, e_ready, e_resp, e_data, m_tmo);
      end
      m_tmo = 1'b0;
      if (m_err == 1) m_err = 2;
      else if (e_ready) begin
        pick = -1;
        for (int i = 4; i >= 0; i--) if (hsel[i]) pick = i;
        m_tgt  = pick;
        m_err  = (pick < 0 && HTRANS[1]) ? 1 : 0;
        m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == 4) begin m_err = 1; m_tmo = 1'b1; m_wait = 0; end
      end
      cyc();
    end
  endtask

  initial begin
    HRESET = 1'b1;
    idle_inputs();
    @(negedge HCLK);
    test_reset();
    test_read_p1();
    test_unmapped();
    test_back_to_back();
    test_watchdog();
    test_no_watchdog();
    test_multi_hsel();
    test_port_disabled();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
